// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 keyboard decoder: FSM encoding,
// protocol constants and the layout of a queued key event.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        ST_BASE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;
    localparam logic [7:0] CODE_ENTER  = 8'h5A;

    // Event entry layout: {ext, break, code[7:0], ascii[7:0]}
    localparam int ENTRY_W   = 18;
    localparam int ASCII_LSB = 0;
    localparam int CODE_LSB  = 8;
    localparam int BRK_BIT   = 16;
    localparam int EXT_BIT   = 17;

    // Keyboard status/ack bytes that carry no key information outside a sequence.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hE1) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key2ascii.sv
// Combinational scan-code set 2 to ASCII translation for a US layout, honouring
// shift and caps-lock. Break handling is done by the caller.
module ps2_key2ascii
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] plain;
    logic [7:0] shifted;

    always_comb begin
        letter  = 8'h00;
        plain   = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h16: {plain, shifted} = {8'h31, 8'h21};
            8'h1E: {plain, shifted} = {8'h32, 8'h40};
            8'h26: {plain, shifted} = {8'h33, 8'h23};
            8'h25: {plain, shifted} = {8'h34, 8'h24};
            8'h2E: {plain, shifted} = {8'h35, 8'h25};
            8'h36: {plain, shifted} = {8'h36, 8'h5E};
            8'h3D: {plain, shifted} = {8'h37, 8'h26};
            8'h3E: {plain, shifted} = {8'h38, 8'h2A};
            8'h46: {plain, shifted} = {8'h39, 8'h28};
            8'h45: {plain, shifted} = {8'h30, 8'h29};
            8'h0E: {plain, shifted} = {8'h60, 8'h7E};
            8'h4E: {plain, shifted} = {8'h2D, 8'h5F};
            8'h55: {plain, shifted} = {8'h3D, 8'h2B};
            8'h54: {plain, shifted} = {8'h5B, 8'h7B};
            8'h5B: {plain, shifted} = {8'h5D, 8'h7D};
            8'h5D: {plain, shifted} = {8'h5C, 8'h7C};
            8'h4C: {plain, shifted} = {8'h3B, 8'h3A};
            8'h52: {plain, shifted} = {8'h27, 8'h22};
            8'h41: {plain, shifted} = {8'h2C, 8'h3C};
            8'h49: {plain, shifted} = {8'h2E, 8'h3E};
            8'h4A: {plain, shifted} = {8'h2F, 8'h3F};
            // Whitespace and control keys ignore shift.
            8'h29: {plain, shifted} = {8'h20, 8'h20};
            8'h5A: {plain, shifted} = {8'h0D, 8'h0D};
            8'h66: {plain, shifted} = {8'h08, 8'h08};
            8'h0D: {plain, shifted} = {8'h09, 8'h09};
            8'h76: {plain, shifted} = {8'h1B, 8'h1B};
            default: ;
        endcase
    end

    always_comb begin
        ascii = 8'h00;
        if (ext) begin
            ascii = (code == CODE_ENTER) ? 8'h0D : 8'h00;
        end else if (letter != 8'h00) begin
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            ascii = shift ? shifted : plain;
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Assembles PS/2 set 2 byte sequences into make/break events, tracks shift and
// caps-lock, and queues {ext, break, code, ascii} events in a show-ahead FIFO.
module ps2_kbd_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd,
    output logic       empty,
    output logic       full,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       shift,
    output logic       caps,
    output logic       overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    state_t state, state_next;
    logic   evt_vld, evt_ext, evt_brk;
    logic   lshift, rshift, caps_held;
    logic [7:0]         ascii_raw;
    logic [ENTRY_W-1:0] entry, head;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic               wr_en, rd_en;

    // Sequence assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_BASE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        evt_vld    = 1'b0;
        evt_ext    = 1'b0;
        evt_brk    = 1'b0;
        if (rx_done_tick) begin
            case (state)
                ST_BASE: begin
                    if (rx_data == CODE_E0)      state_next = ST_EXT;
                    else if (rx_data == CODE_F0) state_next = ST_BRK;
                    else if (!is_discard(rx_data)) evt_vld = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == CODE_F0) begin
                        state_next = ST_EXT_BRK;
                    end else if (rx_data != CODE_E0) begin
                        evt_vld    = 1'b1;
                        evt_ext    = 1'b1;
                        state_next = ST_BASE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (rx_data != CODE_E0 && rx_data != CODE_F0) begin
                        evt_vld    = 1'b1;
                        evt_ext    = (state == ST_EXT_BRK);
                        evt_brk    = 1'b1;
                        state_next = ST_BASE;
                    end
                end
                default: state_next = ST_BASE;
            endcase
        end
    end

    // Translation uses modifier state as it was before this event
    ps2_key2ascii u_key2ascii (
        .code  (rx_data),
        .ext   (evt_ext),
        .shift (shift),
        .caps  (caps),
        .ascii (ascii_raw)
    );

    assign entry = {evt_ext, evt_brk, rx_data, (evt_brk ? 8'h00 : ascii_raw)};
    assign shift = lshift | rshift;

    // Modifier tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (evt_vld && !evt_ext) begin
            if (rx_data == CODE_LSHIFT) lshift <= !evt_brk;
            if (rx_data == CODE_RSHIFT) rshift <= !evt_brk;
            if (rx_data == CODE_CAPS) begin
                if (!evt_brk && !caps_held) caps <= !caps;
                caps_held <= !evt_brk;
            end
        end
    end

    // Event FIFO
    assign rd_en       = rd && !empty;
    assign wr_en       = evt_vld && (!full || rd);
    assign wr_ptr_next = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign rd_ptr_next = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            empty    <= (wr_ptr_next == rd_ptr_next);
            full     <= (wr_ptr_next == {~rd_ptr_next[FIFO_AW], rd_ptr_next[FIFO_AW-1:0]});
            overflow <= overflow | (evt_vld && full && !rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= entry;
    end

    assign head     = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
    assign ev_ext   = head[EXT_BIT];
    assign ev_break = head[BRK_BIT];
    assign ev_code  = head[CODE_LSB +: 8];
    assign ev_ascii = head[ASCII_LSB +: 8];

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: an event-queue model is checked against the
// DUT every cycle, with hand-computed literal expectations along the way.
module tb_ps2_kbd_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd = 1'b0;
    logic       empty, full, ev_ext, ev_break, shift, caps, overflow;
    logic [7:0] ev_code, ev_ascii;

    int n_vec = 0;
    int n_bad = 0;

    ps2_kbd_decoder #(.FIFO_AW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd           (rd),
        .empty        (empty),
        .full         (full),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .ev_ascii     (ev_ascii),
        .shift        (shift),
        .caps         (caps),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    wire [17:0] head = {ev_ext, ev_break, ev_code, ev_ascii};

    task automatic cmp(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference tables ----------------
    logic [7:0] lower_tab [logic [7:0]];
    logic [7:0] plain_tab [logic [7:0]];
    logic [7:0] shift_tab [logic [7:0]];
    logic [7:0] ctrl_tab  [logic [7:0]];

    initial begin
        logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] sym_codes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
            8'h3E, 8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
            8'h41, 8'h49, 8'h4A};
        logic [7:0] plain_s [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
            8'h38, 8'h39, 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
            8'h2C, 8'h2E, 8'h2F};
        logic [7:0] shifted_s [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
            8'h2A, 8'h28, 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
            8'h3C, 8'h3E, 8'h3F};
        for (int i = 0; i < 26; i++) lower_tab[letter_codes[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 21; i++) begin
            plain_tab[sym_codes[i]] = plain_s[i];
            shift_tab[sym_codes[i]] = shifted_s[i];
        end
        ctrl_tab[8'h29] = 8'h20;
        ctrl_tab[8'h5A] = 8'h0D;
        ctrl_tab[8'h66] = 8'h08;
        ctrl_tab[8'h0D] = 8'h09;
        ctrl_tab[8'h76] = 8'h1B;
    end

    function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit ext,
                                               input bit brk, input bit sh, input bit cp);
        if (brk) return 8'h00;
        if (ext) return (code == 8'h5A) ? 8'h0D : 8'h00;
        if (lower_tab.exists(code)) return (sh ^ cp) ? lower_tab[code] - 8'h20 : lower_tab[code];
        if (plain_tab.exists(code)) return sh ? shift_tab[code] : plain_tab[code];
        if (ctrl_tab.exists(code)) return ctrl_tab[code];
        return 8'h00;
    endfunction

    // ---------------- behavioural model ----------------
    logic [17:0] m_q [$];
    bit m_pend_ext = 0, m_pend_brk = 0;
    bit m_lsh = 0, m_rsh = 0, m_caps = 0, m_held = 0, m_ovf = 0;

    always @(posedge clk or posedge reset) begin
        bit ev, e_ext, e_brk, was_full, sh;
        logic [7:0] b;
        if (reset) begin
            m_q.delete();
            m_pend_ext = 0; m_pend_brk = 0;
            m_lsh = 0; m_rsh = 0; m_caps = 0; m_held = 0; m_ovf = 0;
        end else begin
            ev = 0; e_ext = 0; e_brk = 0;
            b = rx_data;
            if (rx_done_tick) begin
                if (b == 8'hE0) begin
                    if (!m_pend_brk) m_pend_ext = 1;
                end else if (b == 8'hF0) begin
                    m_pend_brk = 1;
                end else if (!m_pend_ext && !m_pend_brk &&
                             (b == 8'h00 || b == 8'hAA || b == 8'hE1 ||
                              b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
                end else begin
                    ev = 1; e_ext = m_pend_ext; e_brk = m_pend_brk;
                    m_pend_ext = 0; m_pend_brk = 0;
                end
            end
            was_full = (m_q.size() == 8);
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (ev) begin
                sh = m_lsh | m_rsh;
                if (!was_full || rd) m_q.push_back({e_ext, e_brk, b, model_ascii(b, e_ext, e_brk, sh, m_caps)});
                else m_ovf = 1;
                if (!e_ext) begin
                    if (b == 8'h12) m_lsh = !e_brk;
                    if (b == 8'h59) m_rsh = !e_brk;
                    if (b == 8'h58) begin
                        if (!e_brk && !m_held) m_caps = !m_caps;
                        m_held = !e_brk;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        cmp("empty", 18'(empty), 18'(m_q.size() == 0));
        cmp("full", 18'(full), 18'(m_q.size() == 8));
        cmp("head", head, (m_q.size() == 0) ? 18'h0 : m_q[0]);
        cmp("shift", 18'(shift), 18'(m_lsh | m_rsh));
        cmp("caps", 18'(caps), 18'(m_caps));
        cmp("overflow", 18'(overflow), 18'(m_ovf));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit t, input logic [7:0] d, input bit r);
        rx_done_tick = t; rx_data = d; rd = r;
        @(posedge clk); #1;
        rx_done_tick = 1'b0; rd = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic pop(input string name, input logic [17:0] exp);
        cmp(name, head, exp);
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] fill [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmp("rst_empty", 18'(empty), 18'h1);
        cmp("rst_head", head, 18'h0);
        cmp("rst_flags", {15'h0, shift, caps, overflow}, 18'h0);

        send(8'h1C);
        cmp("a_head", head, {2'b00, 8'h1C, 8'h61});
        cmp("a_empty", 18'(empty), 18'h0);
        step(1'b0, 8'h00, 1'b1);
        cmp("a_pop_empty", 18'(empty), 18'h1);
        cmp("a_pop_head", head, 18'h0);
        step(1'b0, 8'h00, 1'b1);

        send(8'h12);
        cmp("sh_on", 18'(shift), 18'h1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        cmp("sh_off", 18'(shift), 18'h0);
        pop("sh_ev0", {2'b00, 8'h12, 8'h00});
        pop("sh_ev1", {2'b00, 8'h1C, 8'h41});
        pop("sh_ev2", {2'b01, 8'h1C, 8'h00});
        pop("sh_ev3", {2'b01, 8'h12, 8'h00});

        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        cmp("caps_on", 18'(caps), 18'h1);
        send(8'h1C); send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        pop("cp_ev0", {2'b00, 8'h58, 8'h00});
        pop("cp_ev1", {2'b00, 8'h58, 8'h00});
        pop("cp_ev2", {2'b01, 8'h58, 8'h00});
        pop("cp_ev3", {2'b00, 8'h1C, 8'h41});
        pop("cp_ev4", {2'b00, 8'h12, 8'h00});
        pop("cp_ev5", {2'b00, 8'h1C, 8'h61});
        pop("cp_ev6", {2'b01, 8'h12, 8'h00});

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h5A);
        pop("ex_ev0", {2'b10, 8'h75, 8'h00});
        pop("ex_ev1", {2'b11, 8'h75, 8'h00});
        pop("ex_ev2", {2'b10, 8'h5A, 8'h0D});

        send(8'hAA); send(8'hFA);
        cmp("disc_empty", 18'(empty), 18'h1);
        send(8'hF0);
        do_reset();
        send(8'h1C);
        pop("rst_mid_ev", {2'b00, 8'h1C, 8'h61});
        cmp("rst_mid_empty", 18'(empty), 18'h1);

        for (int i = 0; i < 9; i++) begin
            send(fill[i]);
            if (i == 7) cmp("ff_full8", {16'h0, full, overflow}, 18'b10);
        end
        cmp("ff_ovf", 18'(overflow), 18'h1);
        cmp("ff_head", head, {2'b00, 8'h16, 8'h31});
        step(1'b1, 8'h45, 1'b1);
        cmp("ff_rdwr_full", 18'(full), 18'h1);
        cmp("ff_rdwr_head", head, {2'b00, 8'h1E, 8'h32});
        for (int i = 1; i < 8; i++) pop("ff_drain", {2'b00, fill[i], 8'h31 + 8'(i)});
        pop("ff_last", {2'b00, 8'h45, 8'h30});
        cmp("ff_end_empty", 18'(empty), 18'h1);
        cmp("ff_ovf_sticky", 18'(overflow), 18'h1);
        do_reset();
        cmp("ff_ovf_clr", 18'(overflow), 18'h0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_decoder.md
# ps2_kbd_decoder

Consumes the byte stream from the PS/2 receiver, which presents a one-cycle byte strobe plus an 8-bit data byte. Assembles scan-code set 2 sequences (E0/F0 prefixes) into key make/break events and tracks shift and caps-lock state. Each event is tagged with an ASCII translation and queued in a small show-ahead FIFO for the downstream consumer (UART/display/control logic).

## Interface
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- rx_done_tick  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- rd  in  1  pop FIFO head (ignored when empty)
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- ev_code  out  8  head event scan code
- ev_ext  out  1  head event had E0 prefix
- ev_break  out  1  head event is a release
- ev_ascii  out  8  head event ASCII, 0x00 if none
- shift  out  1  left (0x12) or right (0x59) shift held
- caps  out  1  caps-lock toggle state
- overflow  out  1  sticky: event dropped on full FIFO; cleared only by reset

## Operation
- Bytes are processed only on rx_done_tick. Back-to-back ticks on consecutive cycles are legal.
- FSM states:
  - BASE:
    - E0 -> EXT
    - F0 -> BRK
    - 00, AA, E1, FA, FE, FF discarded, no event
    - other byte -> make event (ext=0), stay BASE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> stay EXT
    - other -> make (ext=1) -> BASE
  - BRK:
    - E0/F0 ignored, stay BRK
    - other -> break (ext=0) -> BASE
  - EXT_BRK:
    - E0/F0 ignored
    - other -> break (ext=1) -> BASE
- Pause (E1...) sequences are not decoded. Their trailing bytes produce ordinary events.
- Modifiers, non-extended codes only:
  - 0x12/0x59 make sets its held bit, break clears it; shift = lshift | rshift.
  - 0x58 make toggles caps only if caps_held=0, then sets caps_held. 0x58 break clears caps_held, so typematic repeats do not toggle.
- ASCII is computed from modifier state before the current event's update.
  - Break events and modifier keys: 0x00.
  - Extended events: 0x00, except E0 5A -> 0x0D.
  - Letters: uppercase iff shift XOR caps.
  - Digits and punctuation (` - = [ ] \ ; ' , . /): shifted variant iff shift.
  - 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08, 0x0D -> 0x09, 0x76 -> 0x1B.
  - Unmapped -> 0x00.
- FIFO entry is 18 bits: {ext, break, code, ascii}.
  - Event with FIFO not full: written.
  - Event with FIFO full and rd=0: dropped, overflow set. FSM and modifiers still update.
  - Full with rd=1 and event in the same cycle: both occur, occupancy unchanged.
  - Empty with rd=1: ignored.
- ev_* are forced to 0 while empty.

## Timing
- Reset values:
  - state BASE, FIFO pointers 0
  - empty=1, full=0, overflow=0, shift=0, caps=0, caps_held=0, ev_*=0
- Reset mid-sequence discards any pending prefix.
- Event latency: the event is written on the clock edge where rx_done_tick carries the final byte. empty deasserts and ev_* are valid after that edge (1 cycle).
- shift/caps update on the same edge as the byte that changes them.
- Show-ahead: ev_* reflect the head continuously. After the rd edge, the next entry (or empty=1) is visible.
- full/empty are registered flags derived from pointer compare with wrap bit. Pointers wrap modulo depth.

## Structure
- Package ps2_kbd_pkg holds:
  - FSM state encoding
  - prefix constants (E0, F0)
  - modifier codes (12, 59, 58)
  - discard code list
  - FIFO entry width (18) and field positions
- Sub-module ps2_key2ascii: combinational ROM mapping (code, ext, shift, caps) -> ascii.
- The FSM, modifier registers and FIFO are in the top level.

## Test plan
- Reset, send 1C -> one event {ext0, brk0, 1C, 0x61}; empty falls 1 cycle after the tick. rd -> empty=1, ev_*=0.
- Send 12, 1C, F0 1C, F0 12 -> shift=1 after 12, back to 0 after F0 12. Events in order:
  - make 12 / 0x00
  - make 1C / 0x41
  - break 1C / 0x00
  - break 12 / 0x00
- Send 58, 58, F0 58 -> caps=1 (repeat ignored). Then 1C -> 0x41. Then 12 1C -> 0x61.
- Send E0 75, E0 F0 75, E0 5A -> events:
  - make ext1 75 / 0x00
  - break ext1 75 / 0x00
  - make ext1 5A / 0x0D
- Send AA, FA, then F0, then reset, then 1C -> the AA and FA produce no events. After reset, 1C is reported as a make, not a break.
- FIFO_AW=3:
  - Send 9 makes with no rd -> full after the 8th, 9th dropped, overflow=1.
  - Then rd concurrent with a new tick -> the new event is accepted, full stays 1, head advances.
  - overflow stays 1 until reset.
